// File: rtl/io_fabric.sv
// io_fabric: decodes the 256-byte IO window into word-slot strobes, muxes device read data,
//   watches device acks and keeps an error status register at word slot SELF_ADR.
// Latency: decode/mux is combinational from adr; error logging lands on the next clock edge.
// Backpressure: none; the CPU bus is never stalled, a missing ack is only logged after ACK_TIMEOUT.
// Build option: define IOFAB_IRQ_EN to drive err_irq from a registered copy of err_flag.
module io_fabric #(
  parameter int unsigned          N_DEV       = 8,
  parameter logic [15:0]          IO_BASE     = 16'hFFFF,
  parameter logic [6*N_DEV-1:0]   SLOT_ADR    = '0,
  parameter logic [N_DEV-1:0]     ACK_MASK    = '1,
  parameter logic [5:0]           SELF_ADR    = 6'b101110,
  parameter int unsigned          ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [23:0]           adr,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [31:0]           data_in,
  input  logic [N_DEV*32-1:0]   dev_dout,
  input  logic [N_DEV-1:0]      dev_ack,
  output logic                  ioenb,
  output logic [N_DEV-1:0]      dev_stb,
  output logic [31:0]           io_out,
  output logic                  err_irq
);

  // Ack monitor states; a single bit keeps the encoding compatible with older builds.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [7:0] TMO_CNT = 8'(ACK_TIMEOUT);
  localparam logic [5:0] CNT_MAX = 6'h3F;

  logic [5:0]        word_idx;
  logic              self_hit;
  logic [31:0]       dev_mux;
  logic [31:0]       status_word;

  logic              err_flag;
  logic              err_type;
  logic [5:0]        err_cnt;
  logic [7:0]        err_adr;

  logic [0:0]        state;
  logic [N_DEV-1:0]  wait_mask;
  logic [7:0]        wait_adr;
  logic [7:0]        wait_cnt;

  logic              acc_start;
  logic              mon_start;
  logic              unmapped;
  logic              wait_ack;
  logic              timeout;
  logic              log_err;
  logic              log_type;
  logic [7:0]        log_adr;
  logic              clr_req;
  logic [5:0]        cnt_base;
  logic [5:0]        cnt_next;

  // Byte-lane bits and the unused part of a status write do not take part in decode.
  logic              unused_bits;
  assign unused_bits = ^{adr[1:0], data_in[30:0]};

  // Window and status-register decode.
  always_comb begin
    word_idx = adr[7:2];
    ioenb    = (adr[23:8] == IO_BASE);
    self_hit = ioenb && (word_idx == SELF_ADR);
  end

  // Slot strobes: lowest matching slot wins; the status register shadows any slot at its index.
  always_comb begin
    logic found;
    found   = 1'b0;
    dev_stb = '0;
    for (int i = 0; i < int'(N_DEV); i++) begin
      if (!found && (SLOT_ADR[6*i +: 6] == word_idx)) begin
        dev_stb[i] = 1'b1;
        found      = 1'b1;
      end
    end
    if (!ioenb || self_hit) begin
      dev_stb = '0;
    end
  end

  // Read-data mux: strobes are one-hot, so an AND-OR tree is enough.
  always_comb begin
    dev_mux = '0;
    for (int i = 0; i < int'(N_DEV); i++) begin
      dev_mux = dev_mux | (dev_dout[32*i +: 32] & {32{dev_stb[i]}});
    end
    status_word = {err_flag, err_type, err_cnt, 16'h0000, err_adr};
    io_out      = self_hit ? status_word : dev_mux;
  end

  // Access classification and error-event generation.
  always_comb begin
    acc_start = (rd || wr) && ioenb && (state == ST_IDLE);
    mon_start = acc_start && (|(dev_stb & ACK_MASK)) && !(|(dev_stb & dev_ack));
    unmapped  = acc_start && !(|dev_stb) && !self_hit;
    wait_ack  = |(dev_ack & wait_mask);
    timeout   = (state == ST_WAIT) && !wait_ack && (wait_cnt == TMO_CNT);
    log_err   = unmapped || timeout;
    log_type  = timeout;
    log_adr   = timeout ? wait_adr : adr[7:0];
    clr_req   = self_hit && wr && data_in[31];
    // A clear in the same cycle as a new error restarts the count from zero before incrementing.
    cnt_base  = clr_req ? 6'h00 : err_cnt;
    cnt_next  = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + 6'h01;
  end

  // Status register: a new error always wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err_type <= 1'b0;
      err_cnt  <= 6'h00;
      err_adr  <= 8'h00;
    end else if (log_err) begin
      err_flag <= 1'b1;
      err_type <= log_type;
      err_cnt  <= cnt_next;
      err_adr  <= log_adr;
    end else if (clr_req) begin
      err_flag <= 1'b0;
      err_type <= 1'b0;
      err_cnt  <= 6'h00;
      err_adr  <= 8'h00;
    end
  end

  // Ack monitor: tracks one outstanding access at a time; others pass through unmonitored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_mask <= '0;
      wait_adr  <= 8'h00;
      wait_cnt  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mon_start) begin
            state     <= ST_WAIT;
            wait_mask <= dev_stb;
            wait_adr  <= adr[7:0];
            wait_cnt  <= 8'h01;
          end
        end
        ST_WAIT: begin
          if (wait_ack || timeout) begin
            state     <= ST_IDLE;
            wait_mask <= '0;
          end else begin
            wait_cnt  <= wait_cnt + 8'h01;
          end
        end
        default: begin
          state     <= ST_IDLE;
          wait_mask <= '0;
        end
      endcase
    end
  end

`ifdef IOFAB_IRQ_EN
  // Interrupt follows the error flag one clock later and drops once the flag is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_irq <= 1'b0;
    end else begin
      err_irq <= err_flag;
    end
  end
`else
  assign err_irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_fabric.sv
// tb_io_fabric: directed literal checks plus randomized traffic against a cycle-level model.
// Model works in terms of access events and absolute deadlines, not the DUT's counters.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_io_fabric;

  localparam int          N     = 3;
  localparam int          TMO   = 4;
  localparam logic [23:0] SELF  = 24'hFFFFB8;
  localparam logic [23:0] IDLEA = 24'h000000;
  localparam logic [2:0]  MASK  = 3'b011;
`ifdef IOFAB_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   adr = '0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [31:0]   data_in = '0;
  logic [N*32-1:0] dev_dout = '0;
  logic [N-1:0]  dev_ack = '0;
  logic          ioenb;
  logic [N-1:0]  dev_stb;
  logic [31:0]   io_out;
  logic          err_irq;

  int total = 0;
  int bad   = 0;

  io_fabric #(
    .N_DEV(N), .IO_BASE(16'hFFFF), .SLOT_ADR({6'h32, 6'h31, 6'h30}),
    .ACK_MASK(MASK), .SELF_ADR(6'b101110), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adr(adr), .rd(rd), .wr(wr), .data_in(data_in),
    .dev_dout(dev_dout), .dev_ack(dev_ack), .ioenb(ioenb), .dev_stb(dev_stb),
    .io_out(io_out), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_flag = 0, m_type = 0, m_irq = 0, m_busy = 0;
  int         m_cnt = 0, m_slot = 0, m_deadline = 0, cyc = 0;
  logic [7:0] m_adr = 0, m_madr = 0;

  // Slot i lives at word 0x30+i; the status register at word 0x2E hides nothing here.
  function automatic int slot_of(input logic [23:0] a);
    logic [5:0] w;
    w = a[7:2];
    if (a[23:8] != 16'hFFFF || w == 6'h2E) return -1;
    for (int i = 0; i < N; i++) if (int'(w) == 'h30 + i) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_status();
    return {m_flag, m_type, 6'(m_cnt), 16'h0000, m_adr};
  endfunction

  logic        e_win, e_self, l_log, l_type, old_flag, clr;
  int          e_slot;
  logic [7:0]  l_adr;
  logic [31:0] e_io;
  logic [2:0]  e_stb;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_flag = 0; m_type = 0; m_cnt = 0; m_adr = 0; m_irq = 0; m_busy = 0;
    end
    e_win  = (adr[23:8] == 16'hFFFF);
    e_self = e_win && (adr[7:2] == 6'h2E);
    e_slot = slot_of(adr);
    e_stb  = (e_slot >= 0) ? 3'(1 << e_slot) : 3'b000;
    e_io   = e_self ? m_status() : (e_slot >= 0) ? dev_dout[32*e_slot +: 32] : 32'h0;
    check("ioenb", {31'b0, ioenb}, {31'b0, e_win});
    check("dev_stb", {29'b0, dev_stb}, {29'b0, e_stb});
    check("io_out", io_out, e_io);
    check("err_irq", {31'b0, err_irq}, {31'b0, m_irq});
    if (rst_n) begin
      l_log = 0; l_type = 0; l_adr = 0;
      if (m_busy) begin
        if (dev_ack[m_slot]) m_busy = 0;
        else if (cyc == m_deadline) begin
          l_log = 1; l_type = 1; l_adr = m_madr; m_busy = 0;
        end
      end else if ((rd || wr) && e_win) begin
        if (e_slot < 0 && !e_self) begin
          l_log = 1; l_type = 0; l_adr = adr[7:0];
        end else if (e_slot >= 0 && MASK[e_slot] && !dev_ack[e_slot]) begin
          m_busy = 1; m_slot = e_slot; m_madr = adr[7:0]; m_deadline = cyc + TMO;
        end
      end
      old_flag = m_flag;
      clr = e_self && wr && data_in[31];
      if (clr) begin
        m_flag = 0; m_type = 0; m_cnt = 0; m_adr = 0;
      end
      if (l_log) begin
        m_flag = 1; m_type = l_type; m_adr = l_adr; m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
      end
      m_irq = IRQ_EN & old_flag;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [23:0] a, input logic r, input logic w,
                       input logic [31:0] d, input logic [2:0] ack);
    @(posedge clk); #1;
    adr = a; rd = r; wr = w; data_in = d; dev_ack = ack;
    dev_dout = {$urandom, $urandom, $urandom};
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(IDLEA, 0, 0, 0, 0);
  endtask

  logic [23:0] ra;
  logic [5:0]  rw;
  int          kind, op;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    drive(SELF, 0, 0, 0, 0);
    check("reset_status", io_out, 32'h0);
    check("reset_irq", {31'b0, err_irq}, 32'h0);

    // slot 1 access acked in its second cycle
    drive(24'hFFFFC4, 1, 0, 0, 0);
    check("slot1_stb", {29'b0, dev_stb}, 32'h2);
    check("slot1_data", io_out, dev_dout[63:32]);
    drive(24'hFFFFC4, 0, 0, 0, 3'b010);
    idle(6);
    drive(SELF, 0, 0, 0, 0);
    check("ack_no_err", io_out, 32'h0);

    // slot 0 timeout
    drive(24'hFFFFC0, 1, 0, 0, 0);
    idle(3);
    drive(SELF, 0, 0, 0, 0);
    check("pre_timeout", io_out, 32'h0);
    drive(SELF, 0, 0, 0, 0);
    check("timeout_status", io_out, 32'hC10000C0);
    drive(SELF, 0, 0, 0, 0);
    check("irq_after_err", {31'b0, err_irq}, {31'b0, IRQ_EN});

    // unmapped writes and counter saturation
    drive(SELF, 0, 1, 32'h8000_0000, 0);
    drive(24'hFFFF04, 0, 1, 0, 0);
    drive(SELF, 0, 0, 0, 0);
    check("unmapped_status", io_out, 32'h81000004);
    for (int k = 0; k < 70; k++) drive(24'hFFFF04, 0, 1, 0, 0);
    drive(SELF, 0, 0, 0, 0);
    check("cnt_saturate", io_out, 32'hBF000004);
    drive(SELF, 0, 1, 32'h7FFF_FFFF, 0);
    drive(SELF, 0, 0, 0, 0);
    check("noclear_write", io_out, 32'hBF000004);

    // unmonitored slot 2 never times out
    drive(24'hFFFFC8, 1, 0, 0, 0);
    check("slot2_stb", {29'b0, dev_stb}, 32'h4);
    idle(8);
    drive(SELF, 0, 0, 0, 0);
    check("slot2_no_err", io_out, 32'hBF000004);

    // clear in the same cycle as a timeout: error wins, count restarts at 1
    drive(24'hFFFFC0, 1, 0, 0, 0);
    idle(3);
    drive(SELF, 0, 1, 32'h8000_0000, 0);
    drive(SELF, 0, 0, 0, 0);
    check("clr_vs_timeout", io_out, 32'hC10000C0);

    // clear drops the interrupt
    drive(SELF, 0, 1, 32'h8000_0000, 0);
    drive(SELF, 0, 0, 0, 0);
    check("cleared_status", io_out, 32'h0);
    drive(SELF, 0, 0, 0, 0);
    check("irq_cleared", {31'b0, err_irq}, 32'h0);

    // reset in the middle of a monitored wait, with an error already logged
    drive(24'hFFFF10, 1, 0, 0, 0);
    drive(24'hFFFFC0, 1, 0, 0, 0);
    drive(IDLEA, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; adr = SELF; rd = 0; wr = 0;
    @(negedge clk); #1;
    check("rst_mid_wait", io_out, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) drive(SELF, 0, 0, 0, 0);
    check("post_rst_status", io_out, 32'h0);
    check("post_rst_irq", {31'b0, err_irq}, 32'h0);

    // randomized traffic, checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      kind = $urandom_range(0, 9);
      ra = {16'hFFFF, 8'($urandom)};
      if (kind <= 4) begin
        rw = 6'(6'h30 + $urandom_range(0, 2));
        ra[7:2] = rw;
      end else if (kind == 5) begin
        ra[7:2] = 6'h2E;
      end else if (kind == 6) begin
        rw = 6'($urandom_range(0, 63));
        if (rw == 6'h2E || rw == 6'h30 || rw == 6'h31 || rw == 6'h32) rw = 6'h01;
        ra[7:2] = rw;
      end else begin
        ra = 24'($urandom);
        if (ra[23:8] == 16'hFFFF) ra[23] = 1'b0;
      end
      op = $urandom_range(0, 3);
      drive(ra, op[0], op[1],
            {($urandom_range(0, 7) == 0), 31'($urandom)},
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
